// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that shares one combinational ALU between N_REQ requesters.
// Issues operands, waits a fixed settle time, then returns the captured result.
module alu_rr_scheduler #(
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned CW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [16*N_REQ-1:0]  req_a,
    input  logic [16*N_REQ-1:0]  req_b,
    input  logic [4*N_REQ-1:0]   req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic [1:0]           rsp_error,
    output logic [15:0]          alu_a,
    output logic [15:0]          alu_b,
    output logic [3:0]           alu_op,
    input  logic [31:0]          alu_result,
    input  logic [1:0]           alu_error,
    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]    rsp_result_q, rsp_result_d;
    logic [1:0]     rsp_error_q, rsp_error_d;
    logic [15:0]    alu_a_q, alu_a_d;
    logic [15:0]    alu_b_q, alu_b_d;
    logic [3:0]     alu_op_q, alu_op_d;
    logic [15:0]    op_count_q, op_count_d;

    logic [15:0] a_arr  [N_REQ];
    logic [15:0] b_arr  [N_REQ];
    logic [3:0]  op_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[16*i +: 16];
        assign b_arr[i]  = req_b[16*i +: 16];
        assign op_arr[i] = req_op[4*i +: 4];
    end

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] next_ptr;
    int unsigned    scan_idx;
    logic [3:0]     sel_op;
    logic           sel_legal;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % N_REQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(scan_idx);
            end
        end
    end

    assign next_ptr  = IDW'((32'(grant_idx) + 32'd1) % N_REQ);
    assign sel_op    = op_arr[grant_idx];
    assign sel_legal = (sel_op >= 4'd1) && (sel_op <= 4'd5);

    // Reset gating keeps req_ready low while rst_n is held, whatever req_valid does.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == ST_IDLE) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        op_count_d   = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    rr_ptr_d = next_ptr;
                    rsp_id_d = grant_idx;
                    if (sel_legal) begin
                        alu_a_d  = a_arr[grant_idx];
                        alu_b_d  = b_arr[grant_idx];
                        alu_op_d = sel_op;
                        cnt_d    = CW'(SETTLE_CYCLES - 1);
                        state_d  = ST_WAIT;
                    end else begin
                        // Illegal opcodes never reach the ALU.
                        rsp_result_d = 32'd0;
                        rsp_error_d  = 2'b11;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_result_d = alu_result;
                    rsp_error_d  = alu_error;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    if (op_count_q != 16'hFFFF) begin
                        op_count_d = op_count_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            op_count_q   <= op_count_d;
        end
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed self-checking bench for alu_rr_scheduler with a behavioural ALU attached.
`timescale 1ns/1ps
module tb_alu_rr_scheduler;

    localparam int unsigned N_REQ = 2;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_error;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic [1:0]  alu_error;
    logic        busy;
    logic [15:0] op_count;

    int passed;
    int total;

    alu_rr_scheduler #(
        .N_REQ         (N_REQ),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_error  (alu_error),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 MOD.
    always_comb begin
        alu_result = 32'd0;
        alu_error  = 2'b00;
        case (alu_op)
            4'd1: alu_result = {16'd0, alu_a} + {16'd0, alu_b};
            4'd2: alu_result = {16'd0, alu_a} - {16'd0, alu_b};
            4'd3: alu_result = {16'd0, alu_a} * {16'd0, alu_b};
            4'd4: if (alu_b == 16'd0) alu_error = 2'b10;
                  else alu_result = {16'd0, alu_a / alu_b};
            4'd5: if (alu_b == 16'd0) alu_error = 2'b10;
                  else alu_result = {16'd0, alu_a % alu_b};
            default: alu_error = 2'b11;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 2'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            req_op    = 8'($urandom);
            rsp_ready = 1'($urandom);
            #3;
            total++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b expected 00", req_ready); else passed++;
            total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passed++;
            total++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); else passed++;
            total++; if (rsp_result !== 32'd0) $display("FAIL reset_rsp_result: got %0h expected 0", rsp_result); else passed++;
            total++; if (rsp_error !== 2'b00) $display("FAIL reset_rsp_error: got %b expected 00", rsp_error); else passed++;
            total++; if (alu_a !== 16'd0) $display("FAIL reset_alu_a: got %0h expected 0", alu_a); else passed++;
            total++; if (alu_b !== 16'd0) $display("FAIL reset_alu_b: got %0h expected 0", alu_b); else passed++;
            total++; if (alu_op !== 4'd0) $display("FAIL reset_alu_op: got %0h expected 0", alu_op); else passed++;
            total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
            total++; if (op_count !== 16'd0) $display("FAIL reset_op_count: got %0d expected 0", op_count); else passed++;
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b1;
        req_a     = {16'd0, 16'd3};
        req_b     = {16'd0, 16'd1};
        req_op    = {4'd0, 4'd1};
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) $display("FAIL add_grant: got %b expected 01", req_ready); else passed++;
        step();
        req_valid = 2'b00;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b1) $display("FAIL add_wait1: got valid=%b busy=%b expected valid=0 busy=1", rsp_valid, busy); else passed++;
        total++; if (alu_a !== 16'd3 || alu_b !== 16'd1 || alu_op !== 4'd1) $display("FAIL add_issue: got a=%0d b=%0d op=%0d expected 3 1 1", alu_a, alu_b, alu_op); else passed++;
        step();
        total++; if (rsp_valid !== 1'b0) $display("FAIL add_wait2: got valid=%b expected 0", rsp_valid); else passed++;
        step();
        total++; if (rsp_valid !== 1'b1) $display("FAIL add_latency: got valid=%b expected 1", rsp_valid); else passed++;
        total++; if (rsp_id !== 1'b0) $display("FAIL add_id: got %0d expected 0", rsp_id); else passed++;
        total++; if (rsp_result !== 32'd4) $display("FAIL add_result: got %0d expected 4", rsp_result); else passed++;
        total++; if (rsp_error !== 2'b00) $display("FAIL add_error: got %b expected 00", rsp_error); else passed++;
        step();
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL add_done: got valid=%b busy=%b expected 0 0", rsp_valid, busy); else passed++;
        total++; if (op_count !== 16'd1) $display("FAIL add_op_count: got %0d expected 1", op_count); else passed++;
    endtask

    task automatic test_round_robin();
        int n;
        logic [1:0] exp_grant;
        do_reset();
        rsp_ready = 1'b1;
        req_a     = {16'd7, 16'd3};
        req_b     = {16'd0, 16'd1};
        req_op    = {4'd4, 4'd2};
        req_valid = 2'b11;
        #1;
        for (int t = 0; t < 4; t++) begin
            exp_grant = (t % 2 == 0) ? 2'b01 : 2'b10;
            for (n = 0; n < 8 && req_ready === 2'b00; n++) step();
            total++; if (!$onehot0(req_ready)) $display("FAIL rr_onehot: got %b expected one-hot or zero", req_ready); else passed++;
            total++; if (req_ready !== exp_grant) $display("FAIL rr_grant%0d: got %b expected %b", t, req_ready, exp_grant); else passed++;
            step();
            for (n = 0; n < 8 && rsp_valid !== 1'b1; n++) begin
                total++; if (req_ready !== 2'b00) $display("FAIL rr_ready_busy: got %b expected 00", req_ready); else passed++;
                step();
            end
            total++; if (rsp_valid !== 1'b1) $display("FAIL rr_timeout%0d: got valid=%b expected 1", t, rsp_valid); else passed++;
            if (t % 2 == 0) begin
                total++; if (rsp_id !== 1'b0 || rsp_result !== 32'd2 || rsp_error !== 2'b00)
                    $display("FAIL rr_sub: got id=%0d res=%0d err=%b expected id=0 res=2 err=00", rsp_id, rsp_result, rsp_error);
                else passed++;
            end else begin
                total++; if (rsp_id !== 1'b1 || rsp_error[1] !== 1'b1)
                    $display("FAIL rr_div0: got id=%0d err=%b expected id=1 err[1]=1", rsp_id, rsp_error);
                else passed++;
            end
            step();
        end
        req_valid = 2'b00;
        total++; if (op_count !== 16'd4) $display("FAIL rr_op_count: got %0d expected 4", op_count); else passed++;
    endtask

    task automatic test_illegal_op();
        rsp_ready = 1'b1;
        req_a     = {16'd5, 16'd0};
        req_b     = {16'd6, 16'd0};
        req_op    = {4'd9, 4'd0};
        req_valid = 2'b10;
        #1;
        total++; if (req_ready !== 2'b10) $display("FAIL illegal_grant: got %b expected 10", req_ready); else passed++;
        step();
        req_valid = 2'b00;
        total++; if (rsp_valid !== 1'b1) $display("FAIL illegal_latency: got valid=%b expected 1", rsp_valid); else passed++;
        total++; if (rsp_id !== 1'b1) $display("FAIL illegal_id: got %0d expected 1", rsp_id); else passed++;
        total++; if (rsp_result !== 32'd0 || rsp_error !== 2'b11) $display("FAIL illegal_rsp: got res=%0d err=%b expected 0 11", rsp_result, rsp_error); else passed++;
        total++; if (alu_op !== 4'd4 || alu_a !== 16'd7 || alu_b !== 16'd0) $display("FAIL illegal_alu_hold: got a=%0d b=%0d op=%0d expected 7 0 4", alu_a, alu_b, alu_op); else passed++;
        step();
        total++; if (op_count !== 16'd5 || busy !== 1'b0) $display("FAIL illegal_done: got count=%0d busy=%b expected 5 0", op_count, busy); else passed++;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req_a     = {16'd1, 16'd6};
        req_b     = {16'd1, 16'd7};
        req_op    = {4'd1, 4'd3};
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) $display("FAIL bp_grant: got %b expected 01", req_ready); else passed++;
        step();
        req_a = {16'd1, 16'd100};
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd42 || rsp_id !== 1'b0 || rsp_error !== 2'b00)
                $display("FAIL bp_hold%0d: got valid=%b res=%0d id=%0d err=%b expected 1 42 0 00", i, rsp_valid, rsp_result, rsp_id, rsp_error);
            else passed++;
            total++; if (req_ready !== 2'b00 || busy !== 1'b1 || alu_a !== 16'd6)
                $display("FAIL bp_stall%0d: got ready=%b busy=%b alu_a=%0d expected 00 1 6", i, req_ready, busy, alu_a);
            else passed++;
            step();
        end
        rsp_ready = 1'b1;
        step();
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_release: got valid=%b busy=%b expected 0 0", rsp_valid, busy); else passed++;
        total++; if (op_count !== 16'd6) $display("FAIL bp_count: got %0d expected 6", op_count); else passed++;
        total++; if (req_ready !== 2'b10) $display("FAIL bp_next_grant: got %b expected 10", req_ready); else passed++;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        step();
        total++; if (op_count !== 16'd6 || busy !== 1'b0) $display("FAIL bp_once: got count=%0d busy=%b expected 6 0", op_count, busy); else passed++;
    endtask

    task automatic test_reset_mid_op();
        rsp_ready = 1'b0;
        req_a     = {16'd2, 16'd10};
        req_b     = {16'd2, 16'd20};
        req_op    = {4'd1, 4'd1};
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) $display("FAIL rst_grant: got %b expected 01", req_ready); else passed++;
        step();
        total++; if (busy !== 1'b1) $display("FAIL rst_wait: got busy=%b expected 1", busy); else passed++;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        #1;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_a !== 16'd0 || op_count !== 16'd0)
            $display("FAIL rst_async: got valid=%b busy=%b alu_a=%0d count=%0d expected 0 0 0 0", rsp_valid, busy, alu_a, op_count);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (rsp_valid !== 1'b0) $display("FAIL rst_no_rsp%0d: got %b expected 0", i, rsp_valid); else passed++;
        end
        rst_n     = 1'b1;
        step();
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) $display("FAIL rst_ptr: got %b expected 01", req_ready); else passed++;
        step();
        req_valid = 2'b00;
        step();
        step();
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd30)
            $display("FAIL rst_after: got valid=%b id=%0d res=%0d expected 1 0 30", rsp_valid, rsp_id, rsp_result);
        else passed++;
        step();
        total++; if (op_count !== 16'd1) $display("FAIL rst_count: got %0d expected 1", op_count); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single_add();
        test_round_robin();
        test_illegal_op();
        test_backpressure();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
